// File: rtl/timing_sequencer_if.sv
// timing_sequencer_if: control inputs and timing outputs of the instruction timing sequencer.
interface timing_sequencer_if #(parameter int SC_W = 3);
    logic start;
    logic hlt;
    logic sc_clr;
    logic irq;
    logic ien;
    logic [SC_W-1:0] sc;
    logic run;
    logic r_flag;
    logic sc_ovf;
    modport master(output start, hlt, sc_clr, irq, ien, input sc, run, r_flag, sc_ovf);
    modport slave(input start, hlt, sc_clr, irq, ien, output sc, run, r_flag, sc_ovf);
endinterface

// File: rtl/timing_sequencer.sv
// timing_sequencer: run/stop flip-flop, sequence counter for T0..T7 decode, interrupt-cycle flag and sticky overflow.
module timing_sequencer #(parameter int SC_W = 3) (
    input logic clk,
    input logic rst,
    timing_sequencer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [SC_W-1:0] sc_n;
    logic r_n, ovf_n, irq_take;
    assign bus.run = (state == RUN);
    always_comb begin
        state_n = state;
        sc_n = bus.sc;
        r_n = bus.r_flag;
        ovf_n = bus.sc_ovf;
        // interrupts are only taken after the fetch/decode steps T0..T2
        irq_take = bus.ien && bus.irq && !bus.r_flag && (32'(bus.sc) > 2);
        if (state == IDLE) begin
            if (bus.start && !bus.hlt) begin
                state_n = RUN;
                sc_n = '0;
            end
        end else if (bus.hlt) begin
            state_n = IDLE;
            sc_n = '0;
        end else begin
            sc_n = bus.sc_clr ? '0 : bus.sc + SC_W'(1);
            ovf_n = bus.sc_ovf | (!bus.sc_clr && (&bus.sc));
            r_n = irq_take ? 1'b1 : (bus.r_flag && !bus.sc_clr);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            bus.sc <= '0;
            bus.r_flag <= 1'b0;
            bus.sc_ovf <= 1'b0;
        end else begin
            state <= state_n;
            bus.sc <= sc_n;
            bus.r_flag <= r_n;
            bus.sc_ovf <= ovf_n;
        end
    end
endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer: directed steps with a queue of expected outputs checked one per clock edge.
module tb_timing_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [2:0] sc;
        logic run;
        logic r;
        logic ovf;
        string tag;
    } exp_t;
    exp_t q[$];
    timing_sequencer_if #(.SC_W(3)) bus();
    timing_sequencer #(.SC_W(3)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk1(input string tag, input logic [2:0] o, input logic [2:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask
    task automatic check();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            chk1({e.tag, ".sc"}, bus.sc, e.sc);
            chk1({e.tag, ".run"}, {2'b0, bus.run}, {2'b0, e.run});
            chk1({e.tag, ".r_flag"}, {2'b0, bus.r_flag}, {2'b0, e.r});
            chk1({e.tag, ".sc_ovf"}, {2'b0, bus.sc_ovf}, {2'b0, e.ovf});
        end
    endtask
    task automatic step(input string tag, input logic st, input logic h, input logic c, input logic i, input logic en,
                        input logic [2:0] esc, input logic erun, input logic er, input logic eovf);
        bus.start = st;
        bus.hlt = h;
        bus.sc_clr = c;
        bus.irq = i;
        bus.ien = en;
        q.push_back('{esc, erun, er, eovf, tag});
        @(posedge clk);
        #1;
        check();
    endtask
    initial begin
        bus.start = 1'b0;
        bus.hlt = 1'b0;
        bus.sc_clr = 1'b0;
        bus.irq = 1'b0;
        bus.ien = 1'b0;
        #2;
        q.push_back('{3'd0, 1'b0, 1'b0, 1'b0, "reset"});
        check();
        @(negedge clk);
        rst = 1'b0;
        step("idle_after_reset", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        step("start", 1, 0, 0, 0, 0, 3'd0, 1, 0, 0);
        step("cnt1", 0, 0, 0, 0, 0, 3'd1, 1, 0, 0);
        step("cnt2", 0, 0, 0, 0, 0, 3'd2, 1, 0, 0);
        step("cnt3", 0, 0, 0, 0, 0, 3'd3, 1, 0, 0);
        step("start_ignored", 1, 0, 0, 0, 0, 3'd4, 1, 0, 0);
        step("clr_at4", 0, 0, 1, 0, 0, 3'd0, 1, 0, 0);
        step("after_clr", 0, 0, 0, 1, 0, 3'd1, 1, 0, 0);
        step("clr_again", 0, 0, 1, 0, 0, 3'd0, 1, 0, 0);
        for (int k = 1; k < 8; k++)
            step("wrap_count", 0, 0, 0, 0, 0, 3'(k), 1, 0, 0);
        step("wrap_ovf", 0, 0, 0, 0, 0, 3'd0, 1, 0, 1);
        step("cnt_after_wrap", 0, 0, 0, 0, 0, 3'd1, 1, 0, 1);
        step("ovf_sticky_clr", 0, 0, 1, 0, 0, 3'd0, 1, 0, 1);
        step("irq_at0", 0, 0, 0, 1, 1, 3'd1, 1, 0, 1);
        step("irq_at1", 0, 0, 0, 1, 1, 3'd2, 1, 0, 1);
        step("irq_at2", 0, 0, 0, 1, 1, 3'd3, 1, 0, 1);
        step("irq_at3_clr", 0, 0, 1, 1, 1, 3'd0, 1, 1, 1);
        step("rflag_hold", 0, 0, 0, 0, 1, 3'd1, 1, 1, 1);
        step("rflag_end", 0, 0, 1, 0, 1, 3'd0, 1, 0, 1);
        step("hlt_clears_run", 0, 1, 1, 0, 0, 3'd0, 0, 0, 1);
        step("start_hlt_idle", 1, 1, 0, 0, 0, 3'd0, 0, 0, 1);
        step("restart", 1, 0, 0, 0, 0, 3'd0, 1, 0, 1);
        for (int k = 1; k < 6; k++)
            step("count_to5", 0, 0, 0, 0, 0, 3'(k), 1, 0, 1);
        step("hlt_at5", 1, 1, 1, 1, 1, 3'd0, 0, 0, 1);
        step("idle_hold1", 0, 0, 0, 0, 0, 3'd0, 0, 0, 1);
        step("idle_ignores", 0, 0, 1, 1, 1, 3'd0, 0, 0, 1);
        step("run_again", 1, 0, 0, 0, 0, 3'd0, 1, 0, 1);
        step("r2_cnt1", 0, 0, 0, 0, 0, 3'd1, 1, 0, 1);
        step("r2_cnt2", 0, 0, 0, 0, 0, 3'd2, 1, 0, 1);
        step("r2_cnt3", 0, 0, 0, 0, 0, 3'd3, 1, 0, 1);
        step("irq_at3", 0, 0, 0, 1, 1, 3'd4, 1, 1, 1);
        step("r2_cnt5", 0, 0, 0, 1, 1, 3'd5, 1, 1, 1);
        step("hlt_keeps_rflag", 0, 1, 0, 0, 0, 3'd0, 0, 1, 1);
        step("run_third", 1, 0, 0, 0, 0, 3'd0, 1, 1, 1);
        for (int k = 1; k < 7; k++)
            step("r3_count", 0, 0, 0, 0, 0, 3'(k), 1, 1, 1);
        #2;
        rst = 1'b1;
        #1;
        q.push_back('{3'd0, 1'b0, 1'b0, 1'b0, "async_reset"});
        check();
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_idle", 0, 0, 0, 1, 1, 3'd0, 0, 0, 0);
        step("post_reset_start", 1, 0, 0, 0, 0, 3'd0, 1, 0, 0);
        step("post_reset_cnt", 0, 0, 0, 0, 0, 3'd1, 1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 SHALL have parameter SC_W, default 3, giving the sequence-count width; the count range is 0..2^SC_W-1.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin execution, which sets the run flip-flop.
REQ-005 SHALL have port hlt, input, 1 bit: halt request from control, which clears the run flip-flop.
REQ-006 SHALL have port sc_clr, input, 1 bit: end-of-instruction; returns the count to 0.
REQ-007 SHALL have port irq, input, 1 bit: level interrupt request.
REQ-008 SHALL have port ien, input, 1 bit: interrupt enable.
REQ-009 SHALL have port sc, output, SC_W bits: current timing step, feeding the 3-to-8 timing decoder (T0..T7).
REQ-010 SHALL have port run, output, 1 bit: start/stop flip-flop state.
REQ-011 SHALL have port r_flag, output, 1 bit: interrupt-cycle flip-flop.
REQ-012 SHALL have port sc_ovf, output, 1 bit: sticky flag set when the count wraps without sc_clr.

Function
REQ-013 SHALL keep all outputs registered; none SHALL depend combinationally on inputs.
REQ-014 SHALL, when run=0, hold sc at its current value and ignore sc_clr, irq and ien.
REQ-015 SHALL, when run=0 and start=1 and hlt=0, set run=1 and sc=0 on the next edge.
REQ-016 SHALL, when run=1 and hlt=1, clear run to 0 and sc to 0 on the next edge, regardless of sc_clr.
REQ-017 SHALL give hlt priority when start=1 and hlt=1 in the same cycle, in either run state.
REQ-018 SHALL ignore start while run=1.
REQ-019 SHALL, when run=1, hlt=0 and sc_clr=1, load sc=0 on the next edge.
REQ-020 SHALL, when run=1, hlt=0 and sc_clr=0, increment sc by 1 modulo 2^SC_W on the next edge.
REQ-021 SHALL set sc_ovf=1 on the edge where sc goes from 2^SC_W-1 to 0 by increment, i.e. when sc=max, run=1, sc_clr=0 and hlt=0.
REQ-022 SHALL hold sc_ovf set until reset; sc_clr, hlt and start SHALL NOT clear it.
REQ-023 SHALL set r_flag=1 on the next edge when run=1, ien=1, irq=1, r_flag=0 and sc is not 0, 1 or 2.
REQ-024 SHALL clear r_flag to 0 on the next edge when run=1 and sc_clr=1 while r_flag=1; this is the end of the interrupt cycle.
REQ-025 SHALL, if the REQ-023 condition and sc_clr=1 coincide while r_flag=0, set r_flag=1 and load sc=0.
REQ-026 SHALL leave r_flag unchanged when hlt clears run.
REQ-027 SHALL never cause sc to take a value other than 0, sc+1 mod 2^SC_W, or its held value.

Reset
REQ-028 SHALL, while rst=1 and immediately on its assertion without a clock edge, force sc=0, run=0, r_flag=0 and sc_ovf=0.
REQ-029 SHALL, when rst asserts mid-count, abandon the count and SHALL NOT record an overflow.
REQ-030 SHALL, after rst deasserts, remain idle (run=0) until start is seen on a rising clk edge.

Verification
REQ-031 Bench SHALL cover: reset, then start pulse for 1 cycle -> run=1, sc=0; next edges give sc=1, 2, 3; sc_ovf=0.
REQ-032 Bench SHALL cover: running, sc_clr asserted at sc=4 -> sc=0 next edge, then 1; r_flag stays 0 with ien=0.
REQ-033 Bench SHALL cover: running with no sc_clr for 8 edges from sc=0 -> sc=7, then 0 with sc_ovf=1; sc_ovf stays 1 after later sc_clr.
REQ-034 Bench SHALL cover: ien=1, irq=1 at sc=1 -> no r_flag; at sc=3 -> r_flag=1 next edge; sc_clr -> sc=0, then r_flag cleared on the next sc_clr.
REQ-035 Bench SHALL cover: start=1 and hlt=1 together while idle -> run stays 0; hlt at sc=5 while running -> run=0, sc=0, and sc holds 0 thereafter.
REQ-036 Bench SHALL cover: rst pulse between clock edges at sc=6 with r_flag=1 -> all outputs 0 before the next edge.
